// File: rtl/pipeline_dest_tracker.sv
// Purpose: producer side of the hazard/forwarding interface. Carries each
// instruction's destination register, register-file write enable and load
// flag through EX, MEM and WB. Presents per-stage tags, forwarding data and
// the register-file write port. Injects a NOP into EX on a stall or flush,
// and counts inserted bubbles with a saturating counter.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   id_*                            ID-stage instruction tags and control
//   ex_result                       combinational ALU result of the EX instr
//   mem_load_data                   data-memory read data for the MEM instr
//   rd_*/*_RF_Enable/*_load_instr   per-stage tags for the hazard unit
//   fwd_mem_data, fwd_wb_data       forwarding data from MEM and WB
//   wb_we, wb_addr, wb_data         register-file write port
//   bubble_count                    bubbles inserted since reset
module pipeline_dest_tracker #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [4:0]        id_rd,
    input  logic              id_rf_enable,
    input  logic              id_load_instr,
    input  logic              id_bubble,
    input  logic              id_flush,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] mem_load_data,
    output logic [4:0]        rd_ex,
    output logic [4:0]        rd_mem,
    output logic [4:0]        rd_wb,
    output logic              EX_RF_Enable,
    output logic              MEM_RF_Enable,
    output logic              WB_RF_Enable,
    output logic              EX_load_instr,
    output logic              MEM_load_instr,
    output logic [DATA_W-1:0] fwd_mem_data,
    output logic [DATA_W-1:0] fwd_wb_data,
    output logic              wb_we,
    output logic [4:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic [CNT_W-1:0]  bubble_count
);

    localparam int unsigned RD_W = 5;

    logic insert_nop_c;
    logic ex_rf_en_c;

    // A stall, a flush or an empty ID slot all degenerate into the same NOP.
    assign insert_nop_c = id_bubble | id_flush | ~id_valid;
    // Writes to $0 are discarded so the hazard unit never forwards from it.
    assign ex_rf_en_c   = ~insert_nop_c & id_rf_enable & (id_rd != RD_W'(0));

    // ID -> EX
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ex         <= '0;
            EX_RF_Enable  <= 1'b0;
            EX_load_instr <= 1'b0;
        end else begin
            rd_ex         <= insert_nop_c ? RD_W'(0) : id_rd;
            EX_RF_Enable  <= ex_rf_en_c;
            EX_load_instr <= ~insert_nop_c & id_load_instr;
        end
    end

    // EX -> MEM
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_mem         <= '0;
            MEM_RF_Enable  <= 1'b0;
            MEM_load_instr <= 1'b0;
            fwd_mem_data   <= '0;
        end else begin
            rd_mem         <= rd_ex;
            MEM_RF_Enable  <= EX_RF_Enable;
            MEM_load_instr <= EX_load_instr;
            fwd_mem_data   <= ex_result;
        end
    end

    // MEM -> WB; loads take their result from memory, everything else from the ALU
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_wb        <= '0;
            WB_RF_Enable <= 1'b0;
            fwd_wb_data  <= '0;
        end else begin
            rd_wb        <= rd_mem;
            WB_RF_Enable <= MEM_RF_Enable;
            fwd_wb_data  <= MEM_load_instr ? mem_load_data : fwd_mem_data;
        end
    end

    // Saturating count of stall bubbles
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_count <= '0;
        end else if (id_bubble && (bubble_count != {CNT_W{1'b1}})) begin
            bubble_count <= bubble_count + CNT_W'(1);
        end
    end

    // Register-file write port is the WB stage viewed under another name
    assign wb_we   = WB_RF_Enable;
    assign wb_addr = rd_wb;
    assign wb_data = fwd_wb_data;

endmodule

// File: tb/tb_pipeline_dest_tracker.sv
module tb_pipeline_dest_tracker;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int          MAXC   = 4096;

    logic              clk = 1'b0;
    logic              reset;
    logic              id_valid, id_rf_enable, id_load_instr, id_bubble, id_flush;
    logic [4:0]        id_rd;
    logic [DATA_W-1:0] ex_result, mem_load_data;
    logic [4:0]        rd_ex, rd_mem, rd_wb, wb_addr;
    logic              EX_RF_Enable, MEM_RF_Enable, WB_RF_Enable;
    logic              EX_load_instr, MEM_load_instr, wb_we;
    logic [DATA_W-1:0] fwd_mem_data, fwd_wb_data, wb_data;
    logic [CNT_W-1:0]  bubble_count;

    int checks = 0;
    int errors = 0;

    // Per-edge history of sampled inputs: the model reads outputs off this history.
    logic              s_rst [MAXC];
    logic [6:0]        s_ent [MAXC];   // {ld, en, rd} of what the edge offers to EX
    logic [DATA_W-1:0] s_exr [MAXC];
    logic [DATA_W-1:0] s_mld [MAXC];
    int                t = 0;
    int                m_cnt = 0;

    pipeline_dest_tracker #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rd(id_rd),
        .id_rf_enable(id_rf_enable), .id_load_instr(id_load_instr),
        .id_bubble(id_bubble), .id_flush(id_flush), .ex_result(ex_result),
        .mem_load_data(mem_load_data), .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
        .EX_RF_Enable(EX_RF_Enable), .MEM_RF_Enable(MEM_RF_Enable),
        .WB_RF_Enable(WB_RF_Enable), .EX_load_instr(EX_load_instr),
        .MEM_load_instr(MEM_load_instr), .fwd_mem_data(fwd_mem_data),
        .fwd_wb_data(fwd_wb_data), .wb_we(wb_we), .wb_addr(wb_addr),
        .wb_data(wb_data), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0d)", name, act, exp, t);
        end
    endtask

    // Edge k left the pipeline intact if it existed and was not a reset edge.
    function automatic bit ok(input int k);
        return (k >= 0) && !s_rst[k];
    endfunction

    function automatic logic [6:0] ent(input int k);
        return ok(k) ? s_ent[k] : 7'd0;
    endfunction

    // Compare every output against what the history implies after edge i.
    task automatic check_model(input int i);
        logic [6:0]        e_ex, e_mem, e_wb;
        logic [DATA_W-1:0] e_fm, e_wd;
        logic              mem_ld;
        e_ex  = ent(i);
        e_mem = (ok(i) && ok(i-1)) ? s_ent[i-1] : 7'd0;
        e_wb  = (ok(i) && ok(i-1) && ok(i-2)) ? s_ent[i-2] : 7'd0;
        e_fm  = ok(i) ? s_exr[i] : '0;
        mem_ld = (ok(i-1) && ok(i-2)) ? s_ent[i-2][6] : 1'b0;
        if (!ok(i))      e_wd = '0;
        else if (mem_ld) e_wd = s_mld[i];
        else             e_wd = ok(i-1) ? s_exr[i-1] : '0;
        chk("m_rd_ex",   64'(rd_ex),          64'(e_ex[4:0]));
        chk("m_ex_en",   64'(EX_RF_Enable),   64'(e_ex[5]));
        chk("m_ex_ld",   64'(EX_load_instr),  64'(e_ex[6]));
        chk("m_rd_mem",  64'(rd_mem),         64'(e_mem[4:0]));
        chk("m_mem_en",  64'(MEM_RF_Enable),  64'(e_mem[5]));
        chk("m_mem_ld",  64'(MEM_load_instr), 64'(e_mem[6]));
        chk("m_fwd_mem", 64'(fwd_mem_data),   64'(e_fm));
        chk("m_rd_wb",   64'(rd_wb),          64'(e_wb[4:0]));
        chk("m_wb_en",   64'(WB_RF_Enable),   64'(e_wb[5]));
        chk("m_wb_we",   64'(wb_we),          64'(e_wb[5]));
        chk("m_wb_addr", 64'(wb_addr),        64'(e_wb[4:0]));
        chk("m_fwd_wb",  64'(fwd_wb_data),    64'(e_wd));
        chk("m_wb_data", 64'(wb_data),        64'(e_wd));
        chk("m_bcount",  64'(bubble_count),   64'(m_cnt));
    endtask

    // One clock: record what the edge sees, then check the outputs just after it.
    task automatic step();
        logic nop;
        @(posedge clk);
        nop = id_bubble | id_flush | ~id_valid;
        s_rst[t] = reset;
        s_ent[t] = nop ? 7'd0 : {id_load_instr, id_rf_enable && (id_rd != 5'd0), id_rd};
        s_exr[t] = ex_result;
        s_mld[t] = mem_load_data;
        if (reset) m_cnt = 0;
        else if (id_bubble && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        #1;
        check_model(t);
        t++;
    endtask

    task automatic idle();
        id_valid = 0; id_rd = 0; id_rf_enable = 0; id_load_instr = 0;
        id_bubble = 0; id_flush = 0;
    endtask

    task automatic instr(input logic [4:0] rd, input logic en, input logic ld);
        id_valid = 1; id_rd = rd; id_rf_enable = en; id_load_instr = ld;
        id_bubble = 0; id_flush = 0;
    endtask

    task automatic do_reset();
        idle(); reset = 1; step(); reset = 0;
    endtask

    initial begin
        idle(); reset = 1; ex_result = '0; mem_load_data = '0;
        step(); step(); reset = 0;
        chk("rst_wb_we", 64'(wb_we), 64'd0);
        chk("rst_bcount", 64'(bubble_count), 64'd0);
        chk("rst_rd_ex", 64'(rd_ex), 64'd0);

        // Simple writer through all stages
        instr(5'd5, 1, 0); step();
        chk("w_rd_ex", 64'(rd_ex), 64'd5);
        idle(); ex_result = 32'h11; step();
        chk("w_fwd_mem", 64'(fwd_mem_data), 64'h11);
        chk("w_rd_mem", 64'(rd_mem), 64'd5);
        ex_result = 32'h0; step();
        chk("w_wb_we", 64'(wb_we), 64'd1);
        chk("w_wb_addr", 64'(wb_addr), 64'd5);
        chk("w_wb_data", 64'(wb_data), 64'h11);

        // Load returns memory data
        instr(5'd8, 1, 1); ex_result = 32'h1234; step();
        chk("l_ex_ld", 64'(EX_load_instr), 64'd1);
        idle(); ex_result = 32'h5678; step();
        chk("l_ex_ld_gone", 64'(EX_load_instr), 64'd0);
        chk("l_mem_ld", 64'(MEM_load_instr), 64'd1);
        mem_load_data = 32'hDEADBEEF; step();
        chk("l_wb_data", 64'(wb_data), 64'hDEADBEEF);
        chk("l_wb_addr", 64'(wb_addr), 64'd8);
        mem_load_data = 32'h0;

        // Load followed by a stall bubble
        do_reset();
        instr(5'd9, 1, 1); step();
        instr(5'd10, 1, 0); id_bubble = 1; step();
        chk("b_ex_en", 64'(EX_RF_Enable), 64'd0);
        chk("b_rd_ex", 64'(rd_ex), 64'd0);
        chk("b_mem_ld", 64'(MEM_load_instr), 64'd1);
        chk("b_bcount", 64'(bubble_count), 64'd1);

        // $0 destination never enables a write
        instr(5'd0, 1, 0); step();
        chk("z_ex_en", 64'(EX_RF_Enable), 64'd0);
        idle(); step();
        chk("z_mem_en", 64'(MEM_RF_Enable), 64'd0);
        step();
        chk("z_wb_we", 64'(wb_we), 64'd0);

        // Flush + bubble together is one NOP, one count
        do_reset();
        instr(5'd3, 1, 0); id_bubble = 1; id_flush = 1; step();
        chk("fb_rd_ex", 64'(rd_ex), 64'd0);
        chk("fb_bcount", 64'(bubble_count), 64'd1);

        // Reset with three writers in flight
        instr(5'd1, 1, 0); step();
        instr(5'd2, 1, 0); step();
        instr(5'd3, 1, 0); step();
        reset = 1; step(); reset = 0;
        chk("r_ex_en", 64'(EX_RF_Enable), 64'd0);
        chk("r_mem_en", 64'(MEM_RF_Enable), 64'd0);
        chk("r_wb_we", 64'(wb_we), 64'd0);
        chk("r_bcount", 64'(bubble_count), 64'd0);

        // Counter saturation
        idle(); id_bubble = 1;
        for (int i = 0; i < (1 << CNT_W) + 3; i++) step();
        chk("sat_bcount", 64'(bubble_count), 64'hF);
        idle(); step();
        chk("sat_hold", 64'(bubble_count), 64'hF);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            reset         = ($urandom_range(0, 63) == 0);
            id_valid      = ($urandom_range(0, 3) != 0);
            id_rd         = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            id_rf_enable  = ($urandom_range(0, 3) != 0);
            id_load_instr = ($urandom_range(0, 2) == 0);
            id_bubble     = ($urandom_range(0, 3) == 0);
            id_flush      = ($urandom_range(0, 7) == 0);
            ex_result     = $urandom;
            mem_load_data = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_dest_tracker.md
Name: pipeline_dest_tracker

Overview:
- Producer side of the hazard/forwarding interface.
- Carries each instruction's destination register, register-file write enable and load flag through the EX, MEM and WB stages.
- Presents per-stage rd / RF_Enable / load-flag signals, forwarding data and the register-file write port that the hazard/forwarding unit and datapath consume.
- Inserts a bubble into EX when the hazard unit requests a stall or ID is flushed.

Parameters:
- DATA_W, 32, datapath word width
- CNT_W, 16, width of the saturating bubble counter

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- id_valid  input  1  ID holds a real instruction
- id_rd  input  5  ID destination register
- id_rf_enable  input  1  ID instruction writes the register file
- id_load_instr  input  1  ID instruction is a load
- id_bubble  input  1  hazard unit stall request (control_select / IFID_LE low); insert NOP into EX
- id_flush  input  1  squash the ID instruction (taken branch/jump)
- ex_result  input  DATA_W  combinational ALU result of the EX instruction
- mem_load_data  input  DATA_W  data-memory read data for the MEM instruction
- rd_ex, rd_mem, rd_wb  output  5 each  destination register per stage
- EX_RF_Enable, MEM_RF_Enable, WB_RF_Enable  output  1 each  stage writes the register file
- EX_load_instr  output  1  EX instruction is a load
- MEM_load_instr  output  1  MEM instruction is a load
- fwd_mem_data  output  DATA_W  MEM-stage ALU result, for forwarding
- fwd_wb_data  output  DATA_W  WB-stage final result, for forwarding
- wb_we  output  1  register-file write enable (equals WB_RF_Enable)
- wb_addr  output  5  register-file write address (equals rd_wb)
- wb_data  output  DATA_W  register-file write data (equals fwd_wb_data)
- bubble_count  output  CNT_W  bubbles inserted since reset

Behaviour:
- All outputs are registered.
- On reset, every output and internal register clears to 0. A reset asserted mid-stream discards all in-flight instructions; wb_we is 0 in the cycle after reset.
- Every rising edge advances EX <- ID, MEM <- EX and WB <- MEM. There is no back-pressure: MEM and WB always advance.
- ID -> EX entry:
  - A NOP (rd=0, RF_Enable=0, load=0) enters when id_bubble=1, id_flush=1 or id_valid=0.
  - When id_bubble and id_flush are both 1, the result is the same NOP.
  - Otherwise the ID fields are captured.
- Register-zero rule: if id_rd==0, EX_RF_Enable is captured as 0 even when id_rf_enable=1. A $0 destination never forwards or writes.
- EX -> MEM: rd, RF_Enable and load flag move unchanged. ex_result is captured into fwd_mem_data.
- MEM -> WB: rd and RF_Enable move unchanged. The WB data register captures mem_load_data if MEM_load_instr=1, else fwd_mem_data.
- Latency: an instruction accepted in cycle N appears as rd_ex in N+1, rd_mem in N+2 and rd_wb/wb_we in N+3.
- Load-use window: EX_load_instr is high for exactly one cycle per load. The load reaches MEM one cycle after its bubble-triggering cycle.
- bubble_count increments by 1 on each edge where id_bubble=1 and reset=0, regardless of id_flush or id_valid. It saturates at all-ones; there is no wrap-around.
- The block makes no forwarding decisions; the hazard unit compares its rs/rt against rd_* and *_RF_Enable.

Test Plan:
- Reset, then apply id_valid=1, id_rd=5, id_rf_enable=1, ex_result=0x11 in the EX cycle -> rd_ex=5 at N+1, fwd_mem_data=0x11 and rd_mem=5 at N+2, then wb_we=1, wb_addr=5, wb_data=0x11 at N+3.
- Load with id_rd=8, id_load_instr=1 and mem_load_data=0xDEADBEEF in its MEM cycle -> EX_load_instr=1 for one cycle, MEM_load_instr=1 next cycle, then wb_data=0xDEADBEEF with wb_addr=8.
- Load followed by id_bubble=1 for one cycle -> EX shows NOP in that next cycle (EX_RF_Enable=0, rd_ex=0), load advances to MEM, bubble_count=1.
- id_rd=0 with id_rf_enable=1 -> EX_RF_Enable, MEM_RF_Enable and WB_RF_Enable stay 0 and wb_we is never 1.
- id_flush=1 together with id_bubble=1 -> single NOP enters EX and bubble_count increments once; reset asserted while three valid writers are in flight -> all stage enables and wb_we are 0 the next cycle and bubble_count=0.
- Hold id_bubble=1 for 2^CNT_W+3 cycles (CNT_W overridden to 4) -> bubble_count sticks at 0xF.
